// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter that shares the single register-file write port.
// One request is accepted per clock and issued as a registered WR/DA/D.
module regfile_write_arbiter #(
  parameter int NREQ = 4,
  parameter int n    = 32,
  parameter int m    = 64,
  parameter int AW   = $clog2(n)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*m-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              WR,
  output logic [AW-1:0]     DA,
  output logic [m-1:0]      D,
  output logic [2:0]        last_grant
);

  logic [2:0]    ptr;
  logic [7:0]    valid8;
  logic [7:0]    ready8;
  logic [3:0]    idx;
  logic [2:0]    sel;
  logic          found;
  logic [AW-1:0] addr_sel;
  logic [m-1:0]  data_sel;

  assign valid8 = 8'(req_valid);

  // Search from ptr upward, wrapping modulo NREQ; first valid wins.
  always_comb begin
    found = 1'b0;
    sel   = ptr;
    idx   = 4'd0;
    if (reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = 4'(ptr) + 4'(k);
        if (idx >= 4'(NREQ)) begin
          idx = idx - 4'(NREQ);
        end
        if (!found && valid8[idx[2:0]]) begin
          found = 1'b1;
          sel   = idx[2:0];
        end
      end
    end
  end

  always_comb begin
    ready8 = 8'd0;
    if (found) begin
      ready8 = 8'd1 << sel;
    end
  end

  assign req_ready = ready8[NREQ-1:0];

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == 3'(i)) begin
        addr_sel = req_addr[i*AW +: AW];
        data_sel = req_data[i*m +: m];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr        <= 3'd0;
      WR         <= 1'b0;
      DA         <= '0;
      D          <= '0;
      last_grant <= 3'd0;
    end else if (found) begin
      WR         <= 1'b1;
      DA         <= addr_sel;
      D          <= data_sel;
      last_grant <= sel;
      ptr        <= (sel == 3'(NREQ-1)) ? 3'd0 : sel + 3'd1;
    end else begin
      WR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench: directed cases plus randomized traffic
// compared every cycle against a queue-free round-robin model.
module tb_regfile_write_arbiter;
  localparam int NREQ = 4;
  localparam int N    = 32;
  localparam int M    = 64;
  localparam int AW   = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              hold = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*M-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              WR;
  logic [AW-1:0]     DA;
  logic [M-1:0]      D;
  logic [2:0]        last_grant;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .NREQ(NREQ), .n(N), .m(M), .AW(AW)
  ) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready),
    .WR(WR), .DA(DA), .D(D), .last_grant(last_grant)
  );

  int checks = 0;
  int errors = 0;

  int         mptr;
  int         mlg;
  int         mda;
  bit         mwr;
  logic [M-1:0] md;
  int         g = -1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pick();
    if (!reset || hold) return -1;
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (mptr + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mptr = 0; mwr = 0; mda = 0; md = '0; mlg = 0;
  endtask

  task automatic check_regs();
    chk("WR", 64'(WR), 64'(mwr));
    chk("DA", 64'(DA), 64'(mda));
    chk("D", D, md);
    chk("last_grant", 64'(last_grant), 64'(mlg));
  endtask

  // Inputs must be settled when called; returns 1 after the next edge.
  task automatic cycle();
    #1;
    g = pick();
    chk("req_ready", 64'(req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clock);
    if (g >= 0) begin
      mwr  = 1;
      mda  = int'(req_addr[g*AW +: AW]);
      md   = req_data[g*M +: M];
      mlg  = g;
      mptr = (g + 1) % NREQ;
    end else begin
      mwr = 0;
    end
    #1;
    check_regs();
  endtask

  // Asserts reset between edges, holds it across one edge.
  task automatic async_reset();
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_regs();
    chk("ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clock);
    #1;
    check_regs();
    reset = 1'b1;
  endtask

  task automatic set_req(int i, int addr, logic [M-1:0] data);
    req_addr[i*AW +: AW] = AW'(addr);
    req_data[i*M +: M]   = data;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_WR", 64'(WR), 64'd0);
    chk("rst_DA", 64'(DA), 64'd0);
    chk("rst_D", D, 64'd0);
    chk("rst_lg", 64'(last_grant), 64'd0);
    reset = 1'b1;

    // single requester
    req_valid = 4'b0100;
    set_req(2, 7, 64'hDEAD_BEEF_0000_0001);
    #1 chk("single_ready", 64'(req_ready), 64'b0100);
    cycle();
    chk("single_WR", 64'(WR), 64'd1);
    chk("single_DA", 64'(DA), 64'd7);
    chk("single_D", D, 64'hDEAD_BEEF_0000_0001);
    chk("single_lg", 64'(last_grant), 64'd2);
    req_valid = '0;
    cycle();
    chk("single_WR_drop", 64'(WR), 64'd0);

    // pointer at 3: skip to 0, then pointer moves to 1
    req_valid = 4'b0011;
    set_req(0, 3, 64'hA0);
    set_req(1, 4, 64'hA1);
    #1 chk("wrap_ready", 64'(req_ready), 64'b0001);
    cycle();
    chk("wrap_lg", 64'(last_grant), 64'd0);
    set_req(0, 9, 64'hB0);
    #1 chk("ptr1_ready", 64'(req_ready), 64'b0010);
    cycle();
    chk("ptr1_lg", 64'(last_grant), 64'd1);
    req_valid = '0;
    cycle();

    // hold
    hold = 1'b1;
    req_valid = 4'b0001;
    set_req(0, 12, 64'hC0);
    repeat (3) begin
      #1 chk("hold_ready", 64'(req_ready), 64'd0);
      cycle();
      chk("hold_WR", 64'(WR), 64'd0);
      chk("hold_D", D, 64'hA1);
    end
    hold = 1'b0;
    #1 chk("unhold_ready", 64'(req_ready), 64'b0001);
    cycle();
    chk("unhold_WR", 64'(WR), 64'd1);
    chk("unhold_D", D, 64'hC0);
    req_valid = '0;
    cycle();

    // same-address collision from ptr=0
    async_reset();
    req_valid = 4'b0011;
    set_req(0, 5, 64'h1);
    set_req(1, 5, 64'h2);
    cycle();
    chk("coll1_DA", 64'(DA), 64'd5);
    chk("coll1_D", D, 64'h1);
    req_valid = 4'b0010;
    cycle();
    chk("coll2_WR", 64'(WR), 64'd1);
    chk("coll2_DA", 64'(DA), 64'd5);
    chk("coll2_D", D, 64'h2);
    req_valid = '0;
    cycle();

    // round robin from reset, then reset while writing
    async_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < NREQ; i++) set_req(i, i + 20, 64'(i + 100));
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("rr_lg", 64'(last_grant), 64'(k % 4));
      chk("rr_WR", 64'(WR), 64'd1);
    end
    async_reset();
    req_valid = '0;
    cycle();
    chk("post_rst_WR", 64'(WR), 64'd0);

    // randomized traffic
    g = -1;
    for (int c = 0; c < 3000; c++) begin
      if (g >= 0) begin
        req_valid[g] = 1'($urandom_range(0, 1));
        set_req(g, int'($urandom_range(0, N - 1)),
                {$urandom, $urandom});
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_req(i, int'($urandom_range(0, N - 1)),
                  {$urandom, $urandom});
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 299) == 0) begin
        async_reset();
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Round-robin arbiter that shares the single write port of the 32 x 64 register file among NREQ independent requesters (ALU writeback, load unit, etc.). Each requester presents a valid/ready write request (address + data); one request is accepted per clock and issued to the register file as a registered WR/DA/D triple one cycle later. It sits directly in front of the register file's WR, DA and D inputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- n, 32, register count of the target register file
- m, 64, data width
- AW, 5, address width = log2(n)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- hold  in  1  when 1, no request is accepted this cycle
- req_valid  in  NREQ  request i pending
- req_addr  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*m  packed data, requester i at bits [i*m +: m]
- req_ready  out  NREQ  one-hot (or zero) accept strobe, combinational
- WR  out  1  register file write enable (registered)
- DA  out  AW  register file write address (registered)
- D  out  m  register file write data (registered)
- last_grant  out  3  index of most recently accepted requester (registered)

## Operation
- State: round-robin pointer ptr (0..NREQ-1); output registers WR, DA, D, last_grant.
- Arbitration each cycle: if hold=0, search requesters in order ptr, ptr+1, ..., wrapping modulo NREQ; first i with req_valid[i]=1 wins; req_ready[i]=1, all others 0.
- If hold=1 or req_valid=0: req_ready all 0.
- req_ready depends only on req_valid, ptr, hold; never on itself or on outputs.
- Transfer occurs at a rising edge where req_valid[i] & req_ready[i].
- On transfer from i: WR<=1, DA<=req_addr[i], D<=req_data[i], last_grant<=i, ptr<=(i+1) mod NREQ.
- No transfer: WR<=0; DA, D, last_grant, ptr hold their values.
- Requester obligation: once req_valid[i]=1, keep valid, addr, data stable until the transfer edge.
- Same address from several requesters: each is a separate write in grant order; later write wins in the register file.
- Reset (reset=0, any time, async): ptr=0, WR=0, DA=0, D=0, last_grant=0; req_ready all 0 while reset is low. A request accepted on the edge when reset asserts is discarded (not written).
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once every NREQ cycles.

## Timing
- Accept-to-write latency: 1 cycle (WR high in the cycle after the transfer edge; the register file captures at the next edge).
- Throughput: 1 write per cycle, back-to-back.
- hold takes effect combinationally in the same cycle; releasing hold allows a transfer in that same cycle.
- ptr wrap: grant to NREQ-1 sets ptr=0.
- First edge after reset deasserts may accept a request.

## Test plan
- Reset: reset=0 mid-stream with WR=1 -> WR, DA, D, last_grant, ptr read 0 immediately; no write issued after reset release until a new transfer.
- Single requester: req_valid=4'b0100, addr=7, data=64'hDEAD_BEEF_0000_0001 -> req_ready=4'b0100 same cycle; next cycle WR=1, DA=7, D=64'hDEAD_BEEF_0000_0001, last_grant=2; following cycle WR=0.
- Round robin: req_valid=4'b1111 held 8 cycles from reset -> grants 0,1,2,3,0,1,2,3; WR=1 every cycle from cycle 2.
- Pointer skip/wrap: ptr=3 after grant to 2, req_valid=4'b0011 -> grant 0 (not 1), then ptr=1.
- Hold: req_valid=4'b0001 with hold=1 for 3 cycles -> req_ready=0, WR=0, D unchanged; hold=0 -> accept same cycle, WR=1 next cycle.
- Same address collision: requesters 0 and 1 both write address 5 with 64'h1 and 64'h2, ptr=0 -> WR on two consecutive cycles, DA=5 both, D=1 then 2.
